// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding control slice.
// Holds the register-address width default and the operand-select encodings
// used by both forwarding muxes.
package hazard_forward_ctrl_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EXMM = 2'b01,
    FWD_MMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Operand forwarding select for one source register of the instruction
// leaving RR. The EX stage becomes MM and the MM stage becomes WB on the
// same edge, so those are the two producers that can be bypassed.
// WB-to-RR overlap is covered by the write-first register file.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  use_src,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_valid,
  input  logic                  ex_regwrite,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mm_valid,
  input  logic                  mm_regwrite,
  input  logic [REG_ADDR_W-1:0] mm_rd,
  output fwd_sel_e              sel
);

  logic ex_hit;
  logic mm_hit;

  // The nearer producer (EX/MM) wins whenever both stages write this source.
  always_comb begin
    ex_hit = use_src && (src != '0) && ex_valid && ex_regwrite && (ex_rd == src);
    mm_hit = use_src && (src != '0) && mm_valid && mm_regwrite && (mm_rd == src);
    sel    = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EXMM;
    end else if (mm_hit) begin
      sel = FWD_MMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for a five-stage pipeline.
// Tracks destination info of the EX, MM and WB stages, raises a one-cycle
// load-use stall, and registers the operand selects for the EX instruction.
// Optional: define HAZ_PERF_CNT_EN to add a 32-bit stall_count output.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_rr,
  input  logic [REG_ADDR_W-1:0] rs_rr,
  input  logic [REG_ADDR_W-1:0] rt_rr,
  input  logic                  use_rs_rr,
  input  logic                  use_rt_rr,
  input  logic [REG_ADDR_W-1:0] rd_rr,
  input  logic                  regwrite_rr,
  input  logic                  memread_rr,
  input  logic                  flush,
  output logic [1:0]            Forwarding_control_1,
  output logic [1:0]            Forwarding_control_2,
  output logic                  stall_rr,
  output logic                  bubble_ex
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  logic                  ex_valid, ex_regwrite, ex_memread;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mm_valid, mm_regwrite, mm_memread;
  logic [REG_ADDR_W-1:0] mm_rd;
  logic                  wb_valid, wb_regwrite, wb_memread;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic     load_use;
  logic     insert_bubble;
  fwd_sel_e sel_1, sel_2;
  fwd_sel_e fwd_1_q, fwd_2_q;

  // A load in EX whose result is needed by the RR instruction cannot be
  // bypassed in time; a flush squashes the consumer, so it takes priority.
  always_comb begin
    load_use = valid_rr && ex_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
               ((use_rs_rr && (rs_rr == ex_rd)) || (use_rt_rr && (rt_rr == ex_rd)));
    stall_rr      = load_use && !flush && !reset;
    bubble_ex     = stall_rr;
    insert_bubble = stall_rr || flush || !valid_rr;
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .use_src     (use_rs_rr),
    .src         (rs_rr),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_rd       (ex_rd),
    .mm_valid    (mm_valid),
    .mm_regwrite (mm_regwrite),
    .mm_rd       (mm_rd),
    .sel         (sel_1)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .use_src     (use_rt_rr),
    .src         (rt_rr),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_rd       (ex_rd),
    .mm_valid    (mm_valid),
    .mm_regwrite (mm_regwrite),
    .mm_rd       (mm_rd),
    .sel         (sel_2)
  );

  // Advance destination info every edge; only the RR->EX hop can take a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_rd       <= '0;
      mm_valid    <= 1'b0;
      mm_regwrite <= 1'b0;
      mm_memread  <= 1'b0;
      mm_rd       <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_memread  <= 1'b0;
      wb_rd       <= '0;
      fwd_1_q     <= FWD_RF;
      fwd_2_q     <= FWD_RF;
    end else begin
      if (insert_bubble) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_rd       <= '0;
        fwd_1_q     <= FWD_RF;
        fwd_2_q     <= FWD_RF;
      end else begin
        ex_valid    <= 1'b1;
        ex_regwrite <= regwrite_rr;
        ex_memread  <= memread_rr;
        ex_rd       <= rd_rr;
        fwd_1_q     <= sel_1;
        fwd_2_q     <= sel_2;
      end
      mm_valid    <= ex_valid;
      mm_regwrite <= ex_regwrite;
      mm_memread  <= ex_memread;
      mm_rd       <= ex_rd;
      wb_valid    <= mm_valid;
      wb_regwrite <= mm_regwrite;
      wb_memread  <= mm_memread;
      wb_rd       <= mm_rd;
    end
  end

  assign Forwarding_control_1 = fwd_1_q;
  assign Forwarding_control_2 = fwd_2_q;

  // Bubbles carry no destination, so the tail of the pipe must stay consistent.
  a_wb_write_needs_valid: assert property (@(posedge clk) disable iff (reset)
    (wb_regwrite || wb_memread || mm_memread) |-> (wb_valid || (mm_memread && mm_valid)));
  a_wb_bubble_clears_rd: assert property (@(posedge clk) disable iff (reset)
    !wb_valid |-> (wb_rd == '0));

`ifdef HAZ_PERF_CNT_EN
  // Count stall cycles; plain unsigned add wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 32'd0;
    end else if (stall_rr) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl. Expected selects are pushed to
// a scoreboard queue when an instruction is driven into RR and popped once it
// has moved into EX. Define HAZ_PERF_CNT_EN to also exercise stall_count.
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       reset;
  logic       valid_rr;
  logic [4:0] rs_rr, rt_rr, rd_rr;
  logic       use_rs_rr, use_rt_rr;
  logic       regwrite_rr, memread_rr;
  logic       flush;
  logic [1:0] Forwarding_control_1, Forwarding_control_2;
  logic       stall_rr, bubble_ex;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  exp_t sb[$];

  hazard_forward_ctrl #(.REG_ADDR_W(5)) dut (
    .clk                  (clk),
    .reset                (reset),
    .valid_rr             (valid_rr),
    .rs_rr                (rs_rr),
    .rt_rr                (rt_rr),
    .use_rs_rr            (use_rs_rr),
    .use_rt_rr            (use_rt_rr),
    .rd_rr                (rd_rr),
    .regwrite_rr          (regwrite_rr),
    .memread_rr           (memread_rr),
    .flush                (flush),
    .Forwarding_control_1 (Forwarding_control_1),
    .Forwarding_control_2 (Forwarding_control_2),
    .stall_rr             (stall_rr),
    .bubble_ex            (bubble_ex)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_count          (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls on the clock.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic driveRr(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
    valid_rr    = v;
    rs_rr       = rs;
    use_rs_rr   = urs;
    rt_rr       = rt;
    use_rt_rr   = urt;
    rd_rr       = rd;
    regwrite_rr = rw;
    memread_rr  = mr;
    flush       = fl;
  endtask

  // One RR cycle: check the combinational stall, queue the selects this
  // instruction should carry into EX, then compare them after the edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic fl,
                               input logic exp_stall, input logic [1:0] e1, input logic [1:0] e2);
    exp_t got;
    @(negedge clk);
    driveRr(v, rs, urs, rt, urt, rd, rw, mr, fl);
    #1;
    checkOutput({tag, ".stall"}, 32'(stall_rr), 32'(exp_stall));
    checkOutput({tag, ".bubble"}, 32'(bubble_ex), 32'(exp_stall));
    sb.push_back('{tag, e1, e2});
    @(posedge clk);
    #1;
    checkOutput({tag, ".sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      checkOutput({got.tag, ".fwd1"}, 32'(Forwarding_control_1), 32'(got.f1));
      checkOutput({got.tag, ".fwd2"}, 32'(Forwarding_control_2), 32'(got.f2));
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus("nop", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    end
  endtask

  // Load r2 then add r6,r1,r2: one stall cycle, then MM/WB forward on rt.
  task automatic loadUsePair(input string tag);
    applyStimulus({tag, ".lw"}, 1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus({tag, ".add_stall"}, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 0, 1, 2'b00, 2'b00);
    applyStimulus({tag, ".add_go"}, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b10);
  endtask

  initial begin
    driveRr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.fwd1", 32'(Forwarding_control_1), 32'd0);
    checkOutput("rst.fwd2", 32'(Forwarding_control_2), 32'd0);
    checkOutput("rst.stall", 32'(stall_rr), 32'd0);
    checkOutput("rst.bubble", 32'(bubble_ex), 32'd0);
    reset = 1'b0;

    $display("[TB] EX/MM and MM/WB forwarding");
    applyStimulus("A.add_r3", 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("A.sub_r4", 1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0, 0, 2'b01, 2'b00);
    applyStimulus("A.or_r8", 1, 5'd3, 1, 5'd4, 1, 5'd8, 1, 0, 0, 0, 2'b10, 2'b01);
    applyStimulus("A.and_r9", 1, 5'd3, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00);
    nop(2);

    $display("[TB] load-use stall");
    loadUsePair("B");
    nop(2);

    $display("[TB] double producer priority");
    applyStimulus("C.r7a", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("C.r7b", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("C.rd_r7", 1, 5'd7, 1, 5'd7, 1, 5'd10, 1, 0, 0, 0, 2'b01, 2'b01);
    nop(2);

    $display("[TB] register zero");
    applyStimulus("D.lw_r0", 1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus("D.add_r0", 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("D.rd_r0", 1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0, 0, 2'b00, 2'b00);
    nop(2);

    $display("[TB] unused sources and non-writing producers");
    applyStimulus("E.lw_r5", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus("E.nouse", 1, 5'd5, 0, 5'd2, 1, 5'd14, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("E.sw", 1, 5'd14, 1, 5'd5, 1, 5'd0, 0, 0, 0, 0, 2'b01, 2'b10);
    applyStimulus("E.after_sw", 1, 5'd0, 0, 5'd0, 1, 5'd15, 1, 0, 0, 0, 2'b00, 2'b00);
    nop(2);

    $display("[TB] flush beats load-use");
    applyStimulus("F.lw", 1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus("F.add_flush", 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0, 2'b00, 2'b00);
    applyStimulus("F.fwd_flush", 1, 5'd2, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 2'b00, 2'b00);
    nop(2);

    $display("[TB] reset during a stall");
    applyStimulus("G.addi_r1", 1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("G.lw_r2", 1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0, 0, 2'b01, 2'b00);
    @(negedge clk);
    driveRr(1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 0);
    #1;
    checkOutput("G.pre.stall", 32'(stall_rr), 32'd1);
    checkOutput("G.pre.fwd1", 32'(Forwarding_control_1), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("G.rst.stall", 32'(stall_rr), 32'd0);
    checkOutput("G.rst.bubble", 32'(bubble_ex), 32'd0);
    checkOutput("G.rst.fwd1", 32'(Forwarding_control_1), 32'd0);
    checkOutput("G.rst.fwd2", 32'(Forwarding_control_2), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    driveRr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("G.after", 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
    nop(2);

`ifdef HAZ_PERF_CNT_EN
    $display("[TB] stall counter");
    for (int i = 0; i < 3; i++) begin
      loadUsePair("H");
    end
    @(negedge clk);
    checkOutput("H.count3", stall_count, 32'd3);
    force dut.stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count;
    loadUsePair("H.wrap");
    @(negedge clk);
    checkOutput("H.wrap", stall_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
